// File: rtl/block_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : block_sequencer_pkg
//  Purpose  : Shared game types and constants for the level sequencer.
//  Revision : 1.0
// ============================================================================
package block_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_GAP = 3'd1,
        LAUNCH   = 3'd2,
        ACTIVE   = 3'd3,
        NEXT     = 3'd4,
        DONE     = 3'd5
    } seq_state_t;

    typedef struct packed {
        logic [1:0] lane;
        logic [1:0] speed;
        logic [5:0] gap;
    } note_t;

    localparam logic [1:0] LANE_END     = 2'd3;
    localparam logic [9:0] SCREEN_X_MID = 10'd320;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/block_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : block_sequencer_if
//  Purpose  : Control/outcome link between the level sequencer and block mover.
//  Revision : 1.0
// ============================================================================
interface block_sequencer_if;

    logic       block_restart;
    logic       block_ready;
    logic [9:0] Block_X_Center;
    logic [9:0] Block_Y_Step;
    logic [1:0] Collision;
    logic       end_level;

    modport master (
        output block_restart, block_ready, Block_X_Center, Block_Y_Step,
        input  Collision, end_level
    );

    modport slave (
        input  block_restart, block_ready, Block_X_Center, Block_Y_Step,
        output Collision, end_level
    );

endinterface
`default_nettype wire

// File: rtl/block_sequencer_rom.sv
`default_nettype none
// ============================================================================
//  Module   : block_pattern_rom
//  Purpose  : Combinational level pattern table; all level data lives here.
//  Revision : 1.0
// ============================================================================
module block_pattern_rom
    import block_sequencer_pkg::*;
(
    input  wire logic [3:0] i_note_idx,
    output note_t           o_note
);

    // Unlisted slots read as end-of-pattern.
    always_comb begin
        o_note = {LANE_END, 2'd0, 6'd0};
        case (i_note_idx)
            4'd0:    o_note = {2'd2, 2'd1, 6'd3};
            4'd1:    o_note = {2'd0, 2'd0, 6'd0};
            4'd2:    o_note = {2'd1, 2'd3, 6'd1};
            default: o_note = {LANE_END, 2'd0, 6'd0};
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/block_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : block_sequencer
//  Purpose  : Launches pattern notes to the block mover and keeps hit/miss score.
//  Revision : 1.0
// ============================================================================
module block_sequencer
    import block_sequencer_pkg::*;
#(
    parameter int NUM_NOTES = 16,
    parameter int LANE0_X   = 160,
    parameter int LANE1_X   = 320,
    parameter int LANE2_X   = 480
) (
    input  wire logic         frame_clk,
    input  wire logic         Reset_n,
    input  wire logic         start,
    input  wire logic         restart,
    block_sequencer_if.master blk,
    output logic [3:0]        note_idx,
    output logic [7:0]        score,
    output logic [7:0]        misses,
    output logic              level_done
);

    localparam logic [3:0] c_LAST_IDX = 4'(NUM_NOTES - 1);

    seq_state_t r_state, w_state;
    logic [5:0] r_gap_cnt, w_gap_cnt;
    logic       r_block_restart, w_block_restart;
    logic       r_block_ready, w_block_ready;
    logic [9:0] r_x, w_x;
    logic [9:0] r_step, w_step;
    logic [3:0] r_note_idx, w_note_idx;
    logic [7:0] r_score, w_score;
    logic [7:0] r_misses, w_misses;
    logic       r_level_done, w_level_done;

    logic [3:0] w_rom_addr;
    note_t      w_note;
    logic [9:0] w_lane_x;

    // IDLE looks at the first note, NEXT peeks at the following one.
    always_comb begin
        w_rom_addr = r_note_idx;
        if (r_state == IDLE)
            w_rom_addr = 4'd0;
        else if (r_state == NEXT)
            w_rom_addr = r_note_idx + 4'd1;
    end

    block_pattern_rom u_rom (
        .i_note_idx (w_rom_addr),
        .o_note     (w_note)
    );

    always_comb begin
        case (w_note.lane)
            2'd0:    w_lane_x = 10'(LANE0_X);
            2'd2:    w_lane_x = 10'(LANE2_X);
            default: w_lane_x = 10'(LANE1_X);
        endcase
    end

    always_comb begin
        w_state         = r_state;
        w_gap_cnt       = r_gap_cnt;
        w_block_restart = 1'b0;
        w_block_ready   = 1'b0;
        w_x             = r_x;
        w_step          = r_step;
        w_note_idx      = r_note_idx;
        w_score         = r_score;
        w_misses        = r_misses;
        w_level_done    = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_note_idx = 4'd0;
                    if (w_note.lane == LANE_END) begin
                        w_state      = DONE;
                        w_level_done = 1'b1;
                    end else begin
                        w_gap_cnt = w_note.gap;
                        w_state   = WAIT_GAP;
                    end
                end
            end
            WAIT_GAP: begin
                if (r_gap_cnt == 6'd0) begin
                    w_state         = LAUNCH;
                    w_block_restart = 1'b1;
                    w_x             = w_lane_x;
                    w_step          = 10'(w_note.speed) + 10'd1;
                end else begin
                    w_gap_cnt = r_gap_cnt - 6'd1;
                end
            end
            LAUNCH: begin
                w_state       = ACTIVE;
                w_block_ready = 1'b1;
            end
            ACTIVE: begin
                w_block_ready = 1'b1;
                // A hit wins over a simultaneous fall-off.
                if (|blk.Collision) begin
                    w_score       = sat_inc8(r_score);
                    w_block_ready = 1'b0;
                    w_state       = NEXT;
                end else if (blk.end_level) begin
                    w_misses      = sat_inc8(r_misses);
                    w_block_ready = 1'b0;
                    w_state       = NEXT;
                end
            end
            NEXT: begin
                if (r_note_idx == c_LAST_IDX || w_note.lane == LANE_END) begin
                    w_state      = DONE;
                    w_level_done = 1'b1;
                end else begin
                    w_note_idx = r_note_idx + 4'd1;
                    w_gap_cnt  = w_note.gap;
                    w_state    = WAIT_GAP;
                end
            end
            DONE: begin
                w_level_done = 1'b1;
                if (start) begin
                    w_state      = IDLE;
                    w_level_done = 1'b0;
                end
            end
            default: w_state = IDLE;
        endcase

        if (restart) begin
            w_state         = IDLE;
            w_note_idx      = 4'd0;
            w_score         = 8'd0;
            w_misses        = 8'd0;
            w_block_ready   = 1'b0;
            w_block_restart = 1'b0;
            w_level_done    = 1'b0;
        end
    end

    always_ff @(posedge frame_clk) begin
        if (!Reset_n) begin
            r_state         <= IDLE;
            r_gap_cnt       <= 6'd0;
            r_block_restart <= 1'b0;
            r_block_ready   <= 1'b0;
            r_x             <= 10'(LANE1_X);
            r_step          <= 10'd1;
            r_note_idx      <= 4'd0;
            r_score         <= 8'd0;
            r_misses        <= 8'd0;
            r_level_done    <= 1'b0;
        end else begin
            r_state         <= w_state;
            r_gap_cnt       <= w_gap_cnt;
            r_block_restart <= w_block_restart;
            r_block_ready   <= w_block_ready;
            r_x             <= w_x;
            r_step          <= w_step;
            r_note_idx      <= w_note_idx;
            r_score         <= w_score;
            r_misses        <= w_misses;
            r_level_done    <= w_level_done;
        end
    end

    assign blk.block_restart  = r_block_restart;
    assign blk.block_ready    = r_block_ready;
    assign blk.Block_X_Center = r_x;
    assign blk.Block_Y_Step   = r_step;
    assign note_idx           = r_note_idx;
    assign score              = r_score;
    assign misses             = r_misses;
    assign level_done         = r_level_done;

endmodule
`default_nettype wire

// File: doc/block_sequencer.md
# block_sequencer

Level sequencer for the falling-block game. It drives the block mover: it launches each note onto the screen, gates its fall and chooses its lane and speed. It also consumes the block's outcome (a paddle collision or falling off the bottom) to keep score. Notes come from a small pattern ROM; one block is on screen at a time, and the level ends after the last note.

## Interface
Parameters:
- NUM_NOTES, 16: pattern length; note_idx width is 4.
- LANE0_X, 160: X center for lane code 0.
- LANE1_X, 320: X center for lane code 1.
- LANE2_X, 480: X center for lane code 2.

Ports:
- frame_clk  in  1  single clock, one edge per video frame.
- Reset_n  in  1  synchronous, active-low reset.
- start  in  1  pulse; begins the level from IDLE.
- restart  in  1  pulse; aborts to IDLE from any state.
- Collision  in  2  per-paddle hit flags from the collision logic.
- end_level  in  1  high while the block is below the screen (miss).
- block_restart  out  1  one-frame pulse that re-seats the block at Y=0.
- block_ready  out  1  permits the block to fall.
- Block_X_Center  out  10  lane X center of the current note.
- Block_Y_Step  out  10  pixels per frame for the current note.
- note_idx  out  4  index of the current note.
- score  out  8  hits, saturating at 255.
- misses  out  8  misses, saturating at 255.
- level_done  out  1  high in DONE.

## Operation
- Pattern entry is 10 bits: {lane[1:0], speed[1:0], gap[5:0]}.
- lane 3 is the end-of-pattern marker.
- Block_Y_Step = speed+1, zero-extended to 10 bits, so the step is 1..4 and never 0.
- ROM lookup is combinational on note_idx.
- States:
  - IDLE: outputs quiescent. start → load gap counter with entry[0].gap → WAIT_GAP. If entry[0].lane==3 → DONE.
  - WAIT_GAP: gap counter decrements by 1 per frame. Reaching 0 → LAUNCH (gap 0 gives 1 frame in WAIT_GAP).
  - LAUNCH: one frame. Register Block_X_Center/Block_Y_Step from the entry, block_restart=1, block_ready=0 → ACTIVE.
  - ACTIVE: block_ready=1.
    - Collision[0]|Collision[1] → score+1, → NEXT.
    - Otherwise end_level → misses+1, → NEXT.
    - Both in the same frame counts as a hit only.
  - NEXT: one frame, block_ready=0. If note_idx==NUM_NOTES-1 or entry[note_idx+1].lane==3 → DONE. Otherwise note_idx+1, load gap → WAIT_GAP.
  - DONE: level_done=1, block_ready=0; start → IDLE.
- restart (any state, synchronous) → IDLE. It also clears note_idx, score and misses, drops block_ready, and issues no block_restart.
- Reset_n low has the same effect as restart, plus Block_X_Center=LANE1_X and Block_Y_Step=1.
- Reset values: block_restart 0, block_ready 0, Block_X_Center 320, Block_Y_Step 1, note_idx 0, score 0, misses 0, level_done 0, state IDLE.
- Counters saturate and never wrap. note_idx never exceeds NUM_NOTES-1.
- Collision and end_level are ignored outside ACTIVE. A stale end_level from the previous note cannot score during LAUNCH.

## Timing
- All outputs are registered, changing only on frame_clk edges.
- start sampled at edge k → WAIT_GAP at k+1 → LAUNCH at k+1+(gap+1) → ACTIVE one frame later.
- block_restart is high for exactly one frame, and Block_X_Center/Block_Y_Step are stable in that same frame.
- block_ready rises the frame after block_restart.
- Hit/miss sampled at edge m in ACTIVE: score/misses update and block_ready falls at m+1.
- Frames from the previous outcome to the next block_restart: 1 (NEXT) + gap+1 (WAIT_GAP).
- Reset and restart take priority over every other input on the same edge. Reset_n has priority over restart.

## Structure
- Shared game package holds:
  - typedef seq_state_t {IDLE, WAIT_GAP, LAUNCH, ACTIVE, NEXT, DONE};
  - typedef note_t packed {lane, speed, gap};
  - constants LANE_END=2'd3 and SCREEN_X_MID=320.
- Sub-module block_pattern_rom: combinational, address note_idx, returns note_t, contents as a case table. It is the only place level data lives.

## Test plan
- Reset: hold Reset_n low 2 frames → all outputs at reset values. Release with no start → remains IDLE for 100 frames.
- Launch timing with entry[0]={lane 2, speed 1, gap 3}: start at frame 0 → block_restart at frame 5 with X=480, step=2. block_ready high at frame 6.
- Outcomes:
  - Collision=2'b01 in ACTIVE → score 1, block_ready low next frame, note_idx 1.
  - end_level and Collision=2'b10 in the same frame → score +1, misses unchanged.
- End of pattern: entry[3].lane=3, play all notes as misses → misses 3, DONE, level_done=1. end_level still high → no further increment.
- Restart mid-ACTIVE with score 5 → next frame IDLE, score 0, block_ready 0, no block_restart pulse.
- Saturation: preload 255 hits through a 300-note looped ROM variant → score stays 255.
